fp_round_pack: RTL and testbench
================================

Name: fp_round_pack

Overview:
- Final stage of the single-precision floating-point adder datapath; sits directly downstream of the normalizer.
- Takes the normalized sign, biased exponent and 25-bit mantissa (hidden bit plus 23 fraction bits plus guard), plus a sticky bit.
- Applies round-to-nearest-even, fixes up the exponent on rounding carry, and handles zero, flush-to-zero and overflow-to-infinity.
- Packs an IEEE-754 32-bit word; two-stage pipeline with valid/ready backpressure.

Parameters:
- MANTISSA_N, 25, normalized mantissa width: bit 24 hidden, bits 23:1 fraction, bit 0 guard.
- EXP_N, 8, biased exponent width.
- RESULT_N, 32, packed result width; must equal 1 + EXP_N + (MANTISSA_N-2).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  block can accept this cycle.
- sign  input  1  result sign.
- exp  input  EXP_N  normalized biased exponent, unsigned.
- mantissa  input  MANTISSA_N  normalized mantissa, leading one at bit 24 unless zero.
- sticky  input  1  OR of all bits shifted out below guard.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  RESULT_N  packed IEEE word.
- inexact  output  1  guard or sticky was set.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  nonzero result flushed to zero.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, result=0, inexact=0, overflow=0, underflow=0, both stage valids=0. in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight data; no partial output.
- Handshake: transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
  - in_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || out_ready.
  - Each stage holds its contents while stalled.
  - result and flags are stable while out_valid && !out_ready.
- Latency: 2 cycles, accept edge to out_valid. Throughput 1/cycle with out_ready high. Order preserved. No combinational path from in_valid to out_valid.
- Stage 1 (registered on accept):
  - lsb = mantissa[1], g = mantissa[0].
  - round_up = g & (sticky | lsb).
  - sig25 = {1'b0, mantissa[24:1]} + round_up.
  - inexact = g | sticky.
  - is_zero = (mantissa==0) && !sticky.
  - Register sign, exp, sig25, inexact, is_zero.
- Stage 2 (registered on s1_advance):
  - Carry: if sig25[24], frac = 0 and exp_r = exp + 1 (9-bit add, no wrap). Else frac = sig25[22:0], exp_r = exp.
  - Priority 1, is_zero: result = 32'h00000000 (+0 regardless of sign), flags 0.
  - Priority 2, exp == 0 with nonzero mantissa: result = {sign, 31'b0}, underflow=1.
  - Priority 3, exp_r >= 255: result = {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Otherwise: result = {sign, exp_r[7:0], frac}.
- A mantissa nonzero but with bit 24 clear is a contract violation. The block packs it as-is; no check.
- Back-to-back accept and drain in the same cycle at full occupancy is legal and loses no data.

Test Plan:
- exp=127, mantissa=25'h1000000, sticky=0, sign=0 → two cycles later result=32'h3F800000, all flags 0.
- Tie to even:
  - mantissa=25'h1000001 → 3F800000, inexact=1.
  - mantissa=25'h1000003 → 3F800002, inexact=1.
  - mantissa=25'h1000001 with sticky=1 → 3F800001.
- Rounding carry: exp=127, mantissa=25'h1FFFFFF → 40000000, inexact=1.
- Overflow:
  - exp=254, mantissa=25'h1FFFFFF, sign=0 → 7F800000, overflow=1.
  - sign=1 → FF800000.
  - exp=255 direct → infinity.
- Zero and flush:
  - mantissa=0, sticky=0, sign=1 → 00000000.
  - exp=0, mantissa=25'h1000000, sign=1 → 80000000, underflow=1.
- Backpressure and reset:
  - Stream 4 operands with out_ready=0 → in_ready drops after 2 accepts; result held constant.
  - Raise out_ready → all 4 results emerge in order, no duplicates.
  - Assert reset with 2 in flight → out_valid=0 next cycle; nothing emitted.

Source files
------------

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-to-nearest-even and IEEE-754 single packing, two-stage pipeline
// Stage 1 rounds the significand; stage 2 renormalizes on carry and resolves zero/flush/overflow.
module fp_round_pack #(
  parameter int MANTISSA_N = 25,
  parameter int EXP_N      = 8,
  parameter int RESULT_N   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  sign,
  input  logic [EXP_N-1:0]      exp,
  input  logic [MANTISSA_N-1:0] mantissa,
  input  logic                  sticky,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RESULT_N-1:0]   result,
  output logic                  inexact,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int FRAC_N = MANTISSA_N - 2;

  logic                  s1_valid;
  logic                  s1_sign;
  logic [EXP_N-1:0]      s1_exp;
  logic [MANTISSA_N-1:0] s1_sig;
  logic                  s1_inexact;
  logic                  s1_is_zero;
  logic                  s2_valid;
  logic                  s1_advance;

  logic                  round_up;
  logic [MANTISSA_N-1:0] sig_next;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  assign round_up = mantissa[0] & (sticky | mantissa[1]);
  assign sig_next = {1'b0, mantissa[MANTISSA_N-1:1]} + {{(MANTISSA_N-1){1'b0}}, round_up};

  always_ff @(posedge clock) begin
    if (in_valid && in_ready) begin
      s1_sign    <= sign;
      s1_exp     <= exp;
      s1_sig     <= sig_next;
      s1_inexact <= mantissa[0] | sticky;
      s1_is_zero <= (mantissa == '0) && !sticky;
    end
  end

  logic [EXP_N:0]        exp_r;
  logic [FRAC_N-1:0]     frac;
  logic [RESULT_N-1:0]   pack_result;
  logic                  pack_inexact;
  logic                  pack_overflow;
  logic                  pack_underflow;

  always_comb begin
    exp_r = {1'b0, s1_exp};
    frac  = s1_sig[FRAC_N-1:0];
    // A rounding carry leaves 1.000..0; shifting right by one yields a zero fraction.
    if (s1_sig[MANTISSA_N-1]) begin
      exp_r = {1'b0, s1_exp} + {{EXP_N{1'b0}}, 1'b1};
      frac  = s1_sig[MANTISSA_N-2:1];
    end
    pack_result    = {s1_sign, exp_r[EXP_N-1:0], frac};
    pack_inexact   = s1_inexact;
    pack_overflow  = 1'b0;
    pack_underflow = 1'b0;
    if (s1_is_zero) begin
      pack_result  = '0;
      pack_inexact = 1'b0;
    end else if (s1_exp == '0) begin
      pack_result    = {s1_sign, {(RESULT_N-1){1'b0}}};
      pack_underflow = 1'b1;
    end else if (exp_r >= {1'b0, {EXP_N{1'b1}}}) begin
      pack_result   = {s1_sign, {EXP_N{1'b1}}, {FRAC_N{1'b0}}};
      pack_overflow = 1'b1;
      pack_inexact  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      result    <= '0;
      inexact   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
      end
      // Output word only changes when a new result moves in, so it holds under backpressure.
      if (s1_advance && s1_valid) begin
        result    <= pack_result;
        inexact   <= pack_inexact;
        overflow  <= pack_overflow;
        underflow <= pack_underflow;
      end
    end
  end
endmodule

// File: tb/tb_fp_round_pack.sv
// tb/tb_fp_round_pack.sv - self-checking bench for fp_round_pack
// Directed vectors plus randomized traffic scored against an arithmetic rounding model.
module tb_fp_round_pack;
  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [24:0] mantissa;
  logic        sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        inexact;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  fp_round_pack dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp(exp), .mantissa(mantissa), .sticky(sticky),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .inexact(inexact), .overflow(overflow), .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Operand packing {sign, exp, mantissa, sticky}; expectation {inexact, overflow, underflow, result}.
  localparam logic [34:0] DIR_IN [12] = '{
    {1'b0, 8'd127, 25'h1000000, 1'b0},
    {1'b0, 8'd127, 25'h1000001, 1'b0},
    {1'b0, 8'd127, 25'h1000003, 1'b0},
    {1'b0, 8'd127, 25'h1000001, 1'b1},
    {1'b0, 8'd127, 25'h1FFFFFF, 1'b0},
    {1'b0, 8'd254, 25'h1FFFFFF, 1'b0},
    {1'b1, 8'd254, 25'h1FFFFFF, 1'b0},
    {1'b0, 8'd255, 25'h1000000, 1'b0},
    {1'b1, 8'd100, 25'h0000000, 1'b0},
    {1'b1, 8'd0,   25'h1000000, 1'b0},
    {1'b0, 8'd1,   25'h1000000, 1'b0},
    {1'b0, 8'd254, 25'h1FFFFFE, 1'b0}
  };
  localparam logic [34:0] DIR_EXP [12] = '{
    {3'b000, 32'h3F800000},
    {3'b100, 32'h3F800000},
    {3'b100, 32'h3F800002},
    {3'b100, 32'h3F800001},
    {3'b100, 32'h40000000},
    {3'b110, 32'h7F800000},
    {3'b110, 32'hFF800000},
    {3'b110, 32'h7F800000},
    {3'b000, 32'h00000000},
    {3'b001, 32'h80000000},
    {3'b000, 32'h00800000},
    {3'b000, 32'h7F7FFFFF}
  };

  // Value-level rounding: keep the top 24 bits, round the discarded remainder to nearest, ties to even.
  function automatic logic [34:0] model(input logic [34:0] op);
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic        st;
    logic        g;
    logic        above_half;
    logic        at_half;
    logic [31:0] kept;
    logic [31:0] ex;
    {s, e, m, st} = op;
    kept       = 32'(m) / 2;
    g          = m[0];
    ex         = 32'(e);
    above_half = g && st;
    at_half    = g && !st;
    if (m == 25'd0 && !st) return 35'd0;
    if (e == 8'd0) return {g | st, 1'b0, 1'b1, s, 31'd0};
    if (above_half || (at_half && (kept % 2 == 1))) kept = kept + 1;
    if (kept >= 32'h0100_0000) begin
      kept = kept / 2;
      ex   = ex + 1;
    end
    if (ex >= 255) return {3'b110, s, 8'hFF, 23'd0};
    return {g | st, 2'b00, s, ex[7:0], kept[22:0]};
  endfunction

  function automatic logic [34:0] rand_op();
    logic [31:0] rr;
    logic [7:0]  e;
    logic [24:0] m;
    rr = $urandom();
    case ($urandom_range(0, 7))
      0: e = 8'd0;
      1: e = 8'd1;
      2: e = 8'd254;
      3: e = 8'd255;
      4: e = 8'd253;
      default: e = rr[31:24];
    endcase
    if ($urandom_range(0, 7) == 0) m = 25'd0;
    else if ($urandom_range(0, 5) == 0) m = 25'h1FFFFFF ^ {23'd0, rr[1:0]};
    else m = {1'b1, rr[23:0]};
    return {rr[24], e, m, $urandom_range(0, 1) == 1};
  endfunction

  task automatic drive(input logic [34:0] op);
    {sign, exp, mantissa, sticky} = op;
  endtask

  // One clock: sample handshakes and outputs just before the edge, return 1 time unit after it.
  task automatic cyc(output logic acc, output logic emit, output logic [34:0] obs);
    #1;
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    obs  = {inexact, overflow, underflow, result};
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(35'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++;
    if ({inexact, overflow, underflow} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {inexact, overflow, underflow});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    logic acc, emit;
    logic [34:0] obs;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      drive(DIR_IN[i]);
      cyc(acc, emit, obs);
      in_valid = 1'b0;
      total++;
      if (acc !== 1'b1) begin bad++; $display("FAIL dir%0d_accept got=%b want=1", i, acc); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid); end
      cyc(acc, emit, obs);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency got=%b want=1", i, out_valid); end
      total++;
      if ({inexact, overflow, underflow, result} !== DIR_EXP[i]) begin
        bad++;
        $display("FAIL dir%0d_result got=%h want=%h", i, {inexact, overflow, underflow, result}, DIR_EXP[i]);
      end
      cyc(acc, emit, obs);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, emit;
    logic [34:0] obs;
    logic [34:0] q[$];
    int nacc = 0;
    int nemit = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [34:0] op;
      op = rand_op();
      drive(op);
      cyc(acc, emit, obs);
      if (acc) begin q.push_back(model(op)); nacc++; end
      if (emit && q.size() > 0) begin
        logic [34:0] want;
        want = q.pop_front();
        nemit++;
        total++;
        if (obs !== want) begin bad++; $display("FAIL b2b_result got=%h want=%h", obs, want); end
      end
    end
    in_valid = 1'b0;
    total++;
    if (nacc != 12) begin bad++; $display("FAIL b2b_accepts got=%0d want=12", nacc); end
    total++;
    if (nemit != 10) begin bad++; $display("FAIL b2b_emits got=%0d want=10", nemit); end
    repeat (3) cyc(acc, emit, obs);
  endtask

  task automatic test_backpressure();
    logic acc, emit;
    logic [34:0] obs;
    logic [34:0] ops [4];
    logic [31:0] held;
    int idx = 0;
    int nemit = 0;
    int extra = 0;
    for (int i = 0; i < 4; i++) ops[i] = rand_op();
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 4);
      drive(ops[idx < 4 ? idx : 3]);
      cyc(acc, emit, obs);
      if (acc) idx++;
    end
    total++;
    if (idx != 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", idx); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    total++;
    if ({inexact, overflow, underflow, result} !== model(ops[0])) begin
      bad++; $display("FAIL bp_head got=%h want=%h", {inexact, overflow, underflow, result}, model(ops[0]));
    end
    held = result;
    for (int c = 0; c < 3; c++) begin
      cyc(acc, emit, obs);
      if (acc) idx++;
      total++;
      if (result !== held || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold got=%h/%b want=%h/1", result, out_valid, held);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && nemit < 4; c++) begin
      in_valid = (idx < 4);
      drive(ops[idx < 4 ? idx : 3]);
      cyc(acc, emit, obs);
      if (acc) idx++;
      if (emit) begin
        total++;
        if (obs !== model(ops[nemit])) begin
          bad++; $display("FAIL bp_drain%0d got=%h want=%h", nemit, obs, model(ops[nemit]));
        end
        nemit++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (nemit != 4) begin bad++; $display("FAIL bp_drain_count got=%0d want=4", nemit); end
    for (int c = 0; c < 4; c++) begin
      cyc(acc, emit, obs);
      if (emit) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL bp_duplicates got=%0d want=0", extra); end
  endtask

  task automatic test_reset_midflight();
    logic acc, emit;
    logic [34:0] obs;
    int nacc = 0;
    int nemit = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(rand_op());
      cyc(acc, emit, obs);
      if (acc) nacc++;
    end
    total++;
    if (nacc != 2) begin bad++; $display("FAIL rst_fill got=%0d want=2", nacc); end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_flush_valid got=%b want=0", out_valid); end
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(acc, emit, obs);
      if (emit) nemit++;
    end
    total++;
    if (nemit != 0) begin bad++; $display("FAIL rst_no_emit got=%0d want=0", nemit); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_random();
    logic acc, emit;
    logic [34:0] obs;
    logic [34:0] q[$];
    int nacc = 0;
    int nemit = 0;
    for (int c = 0; c < 600; c++) begin
      logic [34:0] op;
      op        = rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(op);
      cyc(acc, emit, obs);
      if (acc) begin q.push_back(model(op)); nacc++; end
      if (emit) begin
        logic [34:0] want;
        want = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        nemit++;
        total++;
        if (obs !== want) begin bad++; $display("FAIL rand_result got=%h want=%h", obs, want); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc(acc, emit, obs);
      if (emit) begin
        logic [34:0] want;
        want = (q.size() > 0) ? q.pop_front() : 35'h7_FFFF_FFFF;
        nemit++;
        total++;
        if (obs !== want) begin bad++; $display("FAIL rand_drain got=%h want=%h", obs, want); end
      end
    end
    total++;
    if (nemit != nacc) begin bad++; $display("FAIL rand_count got=%0d want=%0d", nemit, nacc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
